// File: rtl/toggle_bank_pkg.sv
// rtl/toggle_bank_pkg.sv - command encoding shared by the toggle bank and its lanes
package toggle_bank_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TOGGLE = 2'b00;
  localparam mode_t MODE_LOAD   = 2'b01;
  localparam mode_t MODE_SET    = 2'b10;
  localparam mode_t MODE_CLEAR  = 2'b11;

endpackage

// File: rtl/toggle_lane.sv
// rtl/toggle_lane.sv - one channel: command register, change pulse, optional counter
// Counter present only when TOGGLE_BANK_CNT_EN is defined.
module toggle_lane
  import toggle_bank_pkg::*;
#(
  parameter int               WIDTH = 8,
`ifdef TOGGLE_BANK_CNT_EN
  parameter int               CNT_W = 8,
`endif
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             chg
`ifdef TOGGLE_BANK_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat
`endif
);

  logic [WIDTH-1:0] nxt;
  logic             changed;

  always_comb begin
    nxt = out;
    unique case (mode)
      MODE_TOGGLE: nxt = out ^ in;
      MODE_LOAD:   nxt = in;
      MODE_SET:    nxt = out | in;
      MODE_CLEAR:  nxt = out & ~in;
      default:     nxt = out;
    endcase
  end

  // Only an enabled command that actually alters the value counts as a change.
  assign changed = en && (nxt != out);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= INIT;
      chg <= 1'b0;
    end else begin
      if (en) out <= nxt;
      chg <= changed;
    end
  end

`ifdef TOGGLE_BANK_CNT_EN
  assign cnt_sat = &cnt;

  // Clear beats increment; increment stops at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt <= '0;
    end else if (changed && !cnt_sat) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/toggle_bank.sv
// rtl/toggle_bank.sv - bank of independent command-driven registers
// Define TOGGLE_BANK_CNT_EN to add per-channel saturating change counters.
module toggle_bank
  import toggle_bank_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 4,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [WIDTH*CHANNELS-1:0] in,
  output logic [WIDTH*CHANNELS-1:0] out,
  output logic [CHANNELS-1:0]       chg
`ifdef TOGGLE_BANK_CNT_EN
  ,
  input  logic [CHANNELS-1:0]       cnt_clr,
  output logic [CNT_W*CHANNELS-1:0] cnt,
  output logic [CHANNELS-1:0]       cnt_sat
`endif
);

  if (WIDTH < 1 || CHANNELS < 1 || CNT_W < 1) begin : g_param_check
    $error("toggle_bank: WIDTH, CHANNELS and CNT_W must all be at least 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    toggle_lane #(
      .WIDTH   (WIDTH),
`ifdef TOGGLE_BANK_CNT_EN
      .CNT_W   (CNT_W),
`endif
      .INIT    (INIT)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .mode    (mode_t'(mode[2*i +: 2])),
      .in      (in[WIDTH*i +: WIDTH]),
      .out     (out[WIDTH*i +: WIDTH]),
      .chg     (chg[i])
`ifdef TOGGLE_BANK_CNT_EN
      ,
      .cnt_clr (cnt_clr[i]),
      .cnt     (cnt[CNT_W*i +: CNT_W]),
      .cnt_sat (cnt_sat[i])
`endif
    );
  end

endmodule
